// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: walks FETCH/DECODE/EXEC/MEM/WB per instruction,
// stalls on the memory ready handshake and traps on illegal encodings or memory timeouts.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [5:0] ALUOp,
    output logic       instr_done,
    output logic [1:0] fault
);

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [5:0] ALUOP_ADD = 6'b100000;
    localparam logic [5:0] ALUOP_SUB = 6'b100010;
    localparam logic [5:0] ALUOP_AND = 6'b100100;
    localparam logic [5:0] ALUOP_OR  = 6'b100101;
    localparam logic [5:0] ALUOP_NOR = 6'b100111;
    localparam logic [5:0] ALUOP_SLT = 6'b101010;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_REXEC, S_RWB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    logic [1:0] fault_q;
    logic       funct_ok;
    logic       mem_timeout;

    // Zero only qualifies PCWriteCond inside the datapath; the sequencer never branches on it.
    logic unused_zero;
    assign unused_zero = Zero;

    assign funct_ok    = (Funct == ALUOP_ADD) || (Funct == ALUOP_AND) || (Funct == ALUOP_OR) ||
                         (Funct == ALUOP_NOR) || (Funct == ALUOP_SLT);
    assign mem_timeout = !mem_ready && (wait_cnt == WAIT_LAST);

    // The wait counter is zeroed on every transition, so it starts clean in each memory state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= 8'd0;
            op_q     <= 6'd0;
            funct_q  <= 6'd0;
            fault_q  <= 2'd0;
        end else begin
            case (state)
                S_FETCH, S_MEMRD, S_MEMWR: begin
                    if (mem_ready) begin
                        wait_cnt <= 8'd0;
                        state    <= (state == S_FETCH) ? S_DECODE :
                                    (state == S_MEMRD) ? S_MEMWB  : S_FETCH;
                    end else if (mem_timeout) begin
                        wait_cnt <= 8'd0;
                        fault_q  <= 2'd2;
                        state    <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    op_q    <= Op;
                    funct_q <= Funct;
                    case (Op)
                        OP_R:         state <= funct_ok ? S_REXEC : S_TRAP;
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_J:         state <= S_JUMP;
                        default:      state <= S_TRAP;
                    endcase
                    if (!((Op == OP_R && funct_ok) || Op == OP_LW || Op == OP_SW ||
                          Op == OP_BEQ || Op == OP_J))
                        fault_q <= 2'd1;
                end
                S_MEMADR: state <= (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
                S_REXEC:  state <= S_RWB;
                S_MEMWB, S_RWB, S_BRANCH, S_JUMP: state <= S_FETCH;
                default:  state <= S_TRAP;
            endcase
        end
    end

    // Moore decode of the current state; only FETCH/MEMWR also look at the handshake.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'd0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUOp       = 6'd0;
        instr_done  = 1'b0;
        fault       = 2'd0;
        if (!rst) begin
            fault = fault_q;
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        ALUSrcB = 2'd1;
                        ALUOp   = ALUOP_ADD;
                        PCWrite = 1'b1;
                    end
                end
                S_DECODE: begin
                    ALUSrcB = 2'd3;
                    ALUOp   = ALUOP_ADD;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                    ALUOp   = ALUOP_ADD;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                S_REXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = funct_q;
                end
                S_RWB: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'd1;
                    instr_done  = 1'b1;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'd2;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle and
// compares the full control word against hand-written per-state vectors.
module tb_multicycle_ctrl;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Op = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, instr_done;
    logic [1:0] PCSource, ALUSrcB, fault;
    logic [5:0] ALUOp;

    int checks = 0;
    int failures = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clock), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .instr_done(instr_done), .fault(fault)
    );

    always #5 clock = ~clock;

    // Control word in port order: PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
    // IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, instr_done, fault.
    function automatic logic [22:0] mk(input logic pcw, input logic pcwc, input logic [1:0] pcs,
                                       input logic iord, input logic mr, input logic mw,
                                       input logic irw, input logic rd, input logic m2r,
                                       input logic rw, input logic asa, input logic [1:0] asb,
                                       input logic [5:0] aop, input logic done,
                                       input logic [1:0] flt);
        return {pcw, pcwc, pcs, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, done, flt};
    endfunction

    logic [22:0] ctrlWord;
    assign ctrlWord = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst,
                       MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, instr_done, fault};

    logic [22:0] eIdle, eFetchWait, eFetchGo, eDecode, eMemAdr, eMemRd, eMemWb;
    logic [22:0] eMemWr, eMemWrGo, eRwb, eBranch, eJump, eTrap1, eTrap2;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstv, input logic rdy);
        rst = rstv;
        mem_ready = rdy;
        #2;
    endtask

    task automatic cycle(input string tag, input logic rstv, input logic rdy, input logic [22:0] expected);
        applyStimulus(rstv, rdy);
        checkOutput(tag, 32'(ctrlWord), 32'(expected));
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        cycle("reset0", 1'b1, 1'b1, eIdle);
        cycle("reset1", 1'b1, 1'b1, eIdle);
    endtask

    logic [5:0] rFunct [4];
    initial begin
        rFunct[0] = 6'b100000;
        rFunct[1] = 6'b100100;
        rFunct[2] = 6'b100101;
        rFunct[3] = 6'b100111;
    end

    initial begin
        eIdle      = '0;
        eFetchWait = mk(0,0,0, 0,1,0, 0,0,0,0, 0,0, 6'd0, 0, 0);
        eFetchGo   = mk(1,0,0, 0,1,0, 1,0,0,0, 0,1, ADD,  0, 0);
        eDecode    = mk(0,0,0, 0,0,0, 0,0,0,0, 0,3, ADD,  0, 0);
        eMemAdr    = mk(0,0,0, 0,0,0, 0,0,0,0, 1,2, ADD,  0, 0);
        eMemRd     = mk(0,0,0, 1,1,0, 0,0,0,0, 0,0, 6'd0, 0, 0);
        eMemWb     = mk(0,0,0, 0,0,0, 0,0,1,1, 0,0, 6'd0, 1, 0);
        eMemWr     = mk(0,0,0, 1,0,1, 0,0,0,0, 0,0, 6'd0, 0, 0);
        eMemWrGo   = mk(0,0,0, 1,0,1, 0,0,0,0, 0,0, 6'd0, 1, 0);
        eRwb       = mk(0,0,0, 0,0,0, 0,1,0,1, 0,0, 6'd0, 1, 0);
        eBranch    = mk(0,1,1, 0,0,0, 0,0,0,0, 1,0, SUB,  1, 0);
        eJump      = mk(1,0,2, 0,0,0, 0,0,0,0, 0,0, 6'd0, 1, 0);
        eTrap1     = mk(0,0,0, 0,0,0, 0,0,0,0, 0,0, 6'd0, 0, 1);
        eTrap2     = mk(0,0,0, 0,0,0, 0,0,0,0, 0,0, 6'd0, 0, 2);

        @(posedge clock);
        #1;
        doReset();

        // R-type: add then the other legal functs, plus slt, each 4 cycles.
        Op = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            Funct = rFunct[i];
            cycle("r_fetch", 1'b0, 1'b1, eFetchGo);
            cycle("r_decode", 1'b0, 1'b1, eDecode);
            cycle("r_exec", 1'b0, 1'b1, mk(0,0,0, 0,0,0, 0,0,0,0, 1,0, rFunct[i], 0, 0));
            cycle("r_wb", 1'b0, 1'b1, eRwb);
        end
        Funct = 6'b101010;
        cycle("slt_fetch", 1'b0, 1'b1, eFetchGo);
        cycle("slt_decode", 1'b0, 1'b1, eDecode);
        cycle("slt_exec", 1'b0, 1'b1, mk(0,0,0, 0,0,0, 0,0,0,0, 1,0, 6'b101010, 0, 0));
        cycle("slt_wb", 1'b0, 1'b1, eRwb);

        // lw with three wait cycles in MEMRD: CPI 8.
        Op = 6'b100011;
        cycle("lw_fetch", 1'b0, 1'b1, eFetchGo);
        cycle("lw_decode", 1'b0, 1'b1, eDecode);
        cycle("lw_memadr", 1'b0, 1'b1, eMemAdr);
        for (int i = 0; i < 3; i++) cycle("lw_memrd_wait", 1'b0, 1'b0, eMemRd);
        cycle("lw_memrd_go", 1'b0, 1'b1, eMemRd);
        cycle("lw_memwb", 1'b0, 1'b1, eMemWb);

        // beq with Zero=1 and Zero=0: identical control words.
        Op = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            Zero = z[0];
            cycle("beq_fetch", 1'b0, 1'b1, eFetchGo);
            cycle("beq_decode", 1'b0, 1'b1, eDecode);
            cycle("beq_branch", 1'b0, 1'b1, eBranch);
        end
        Zero = 1'b0;

        // j, then sw with zero wait.
        Op = 6'b000010;
        cycle("j_fetch", 1'b0, 1'b1, eFetchGo);
        cycle("j_decode", 1'b0, 1'b1, eDecode);
        cycle("j_jump", 1'b0, 1'b1, eJump);
        Op = 6'b101011;
        cycle("sw_fetch", 1'b0, 1'b1, eFetchGo);
        cycle("sw_decode", 1'b0, 1'b1, eDecode);
        cycle("sw_memadr", 1'b0, 1'b1, eMemAdr);
        cycle("sw_memwr", 1'b0, 1'b1, eMemWrGo);
        cycle("sw_next_fetch", 1'b0, 1'b0, eFetchWait);
        doReset();

        // addi is illegal: sticky fault 1 for 20 cycles, cleared by reset.
        Op = 6'b001000;
        cycle("addi_fetch", 1'b0, 1'b1, eFetchGo);
        cycle("addi_decode", 1'b0, 1'b1, eDecode);
        for (int i = 0; i < 20; i++) cycle("addi_trap", 1'b0, 1'b1, eTrap1);
        doReset();
        cycle("addi_after_reset", 1'b0, 1'b0, eFetchWait);
        doReset();

        // R-type with a bad funct also traps.
        Op = 6'b000000;
        Funct = 6'b100010;
        cycle("badf_fetch", 1'b0, 1'b1, eFetchGo);
        cycle("badf_decode", 1'b0, 1'b1, eDecode);
        cycle("badf_trap", 1'b0, 1'b1, eTrap1);
        doReset();

        // Fetch timeout: 15 cycles of MemRead, then fault 2.
        for (int i = 0; i < 15; i++) cycle("to_fetch_wait", 1'b0, 1'b0, eFetchWait);
        cycle("to_trap", 1'b0, 1'b0, eTrap2);
        cycle("to_trap_hold", 1'b0, 1'b1, eTrap2);
        doReset();

        // Ready on the 15th cycle wins over the timeout.
        Op = 6'b000010;
        for (int i = 0; i < 14; i++) cycle("edge_fetch_wait", 1'b0, 1'b0, eFetchWait);
        cycle("edge_fetch_go", 1'b0, 1'b1, eFetchGo);
        cycle("edge_decode", 1'b0, 1'b0, eDecode);
        cycle("edge_jump", 1'b0, 1'b0, eJump);
        doReset();

        // sw aborted by reset while waiting in MEMWR.
        Op = 6'b101011;
        cycle("swr_fetch", 1'b0, 1'b1, eFetchGo);
        cycle("swr_decode", 1'b0, 1'b0, eDecode);
        cycle("swr_memadr", 1'b0, 1'b0, eMemAdr);
        cycle("swr_memwr", 1'b0, 1'b0, eMemWr);
        cycle("swr_reset", 1'b1, 1'b1, eIdle);
        cycle("swr_fetch_after", 1'b0, 1'b0, eFetchWait);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
